// File: rtl/remote_nec_decoder_if.sv
// Bundle between the IR cleaner, the NEC decoder and the control/volume logic.
// master = decoder side (consumes Input, drives the decoded results and strobes).
interface remote_nec_decoder_if;
    logic        Input;
    logic [15:0] Address;
    logic [7:0]  Command;
    logic        Valid;
    logic        Repeat;
    logic        Error;

    modport master (input Input, output Address, Command, Valid, Repeat, Error);
    modport slave  (output Input, input Address, Command, Valid, Repeat, Error);
endinterface

// File: rtl/remote_nec_decoder.sv
// NEC IR frame decoder: times mark/space segments in prescaled ticks and walks a frame FSM.
// Define NEC_EXT_ADDR_EN for extended NEC (16-bit address, no address inverse check).
module remote_nec_decoder #(
    parameter int unsigned TICK_DIV      = 1758,
    parameter int unsigned SPACE_TIMEOUT = 400
) (
    input logic                  Clk,
    input logic                  Reset,
    remote_nec_decoder_if.master nec
);

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StRptMark
    } state_e;

    localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);
    localparam logic [9:0]  SpaceTo  = 10'(SPACE_TIMEOUT);
    localparam logic [9:0]  DurMax   = 10'h3FF;

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [9:0]  dur_q, dur_d;
    logic        in_q, prev_q;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  idx_q, idx_d;
    logic        held_q, held_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        valid_q, valid_d;
    logic        repeat_q, repeat_d;
    logic        error_q, error_d;

    logic        edge_seen, tick;
    logic        is_leader, is_frame_sp, is_rpt_sp, is_short, is_long;
    logic        cmd_ok, addr_ok;
    logic [15:0] addr_val;

    assign edge_seen = (in_q != prev_q);
    assign tick      = (presc_q == TickLast);

    assign is_leader   = (dur_q >= 10'd192) && (dur_q <= 10'd320);
    assign is_frame_sp = (dur_q >= 10'd96)  && (dur_q <= 10'd160);
    assign is_rpt_sp   = (dur_q >= 10'd48)  && (dur_q <= 10'd80);
    assign is_short    = (dur_q >= 10'd8)   && (dur_q <= 10'd24);
    assign is_long     = (dur_q >= 10'd36)  && (dur_q <= 10'd60);

    assign cmd_ok = (shift_q[31:24] == ~shift_q[23:16]);
`ifdef NEC_EXT_ADDR_EN
    assign addr_ok  = 1'b1;
    assign addr_val = shift_q[15:0];
`else
    assign addr_ok  = (shift_q[15:8] == ~shift_q[7:0]);
    assign addr_val = {8'h00, shift_q[7:0]};
`endif

    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        dur_d    = (tick && dur_q != DurMax) ? dur_q + 10'd1 : dur_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        held_d   = held_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        valid_d  = 1'b0;
        repeat_d = 1'b0;
        error_d  = 1'b0;

        if (edge_seen) begin
            presc_d = 16'd0;
            dur_d   = 10'd0;
            // dur_q still holds the length of the segment that this edge just closed
            unique case (state_q)
                StIdle: begin
                    if (!in_q) state_d = StLeadMark;
                end
                StLeadMark: begin
                    state_d = is_leader ? StLeadSpace : StIdle;
                end
                StLeadSpace: begin
                    if (is_frame_sp) begin
                        state_d = StBitMark;
                        idx_d   = 5'd0;
                    end else if (is_rpt_sp) begin
                        state_d = StRptMark;
                    end else begin
                        state_d = StIdle;
                        error_d = 1'b1;
                    end
                end
                StBitMark: begin
                    if (is_short) begin
                        state_d = StBitSpace;
                    end else begin
                        state_d = StIdle;
                        error_d = 1'b1;
                    end
                end
                StBitSpace: begin
                    if (is_short || is_long) begin
                        shift_d = {is_long, shift_q[31:1]};
                        if (idx_q == 5'd31) begin
                            state_d = StStopMark;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = StBitMark;
                        end
                    end else begin
                        state_d = StIdle;
                        error_d = 1'b1;
                    end
                end
                StStopMark: begin
                    state_d = StIdle;
                    if (is_short && cmd_ok && addr_ok) begin
                        valid_d = 1'b1;
                        addr_d  = addr_val;
                        cmd_d   = shift_q[23:16];
                        held_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                StRptMark: begin
                    state_d = StIdle;
                    if (!is_short)   error_d  = 1'b1;
                    else if (held_q) repeat_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle &&
                     ((in_q && dur_q >= SpaceTo) || (!in_q && dur_q == DurMax))) begin
            state_d = StIdle;
            error_d = 1'b1;
        end

        if (error_d) held_d = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= StIdle;
            presc_q  <= 16'd0;
            dur_q    <= 10'd0;
            in_q     <= 1'b1;
            prev_q   <= 1'b1;
            shift_q  <= 32'd0;
            idx_q    <= 5'd0;
            held_q   <= 1'b0;
            addr_q   <= 16'd0;
            cmd_q    <= 8'd0;
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dur_q    <= dur_d;
            in_q     <= nec.Input;
            prev_q   <= in_q;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            held_q   <= held_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            valid_q  <= valid_d;
            repeat_q <= repeat_d;
            error_q  <= error_d;
        end
    end

    assign nec.Address = addr_q;
    assign nec.Command = cmd_q;
    assign nec.Valid   = valid_q;
    assign nec.Repeat  = repeat_q;
    assign nec.Error   = error_q;

endmodule

// File: tb/tb_remote_nec_decoder.sv
// Directed bench for remote_nec_decoder at TICK_DIV=4 (one tick = 4 clocks).
// Expectations follow NEC_EXT_ADDR_EN if it is defined for the build.
module tb_remote_nec_decoder;

    localparam int TD = 4;
    localparam int ST = 400;

    logic Clk;
    logic Reset;
    remote_nec_decoder_if nec ();

    remote_nec_decoder #(
        .TICK_DIV      (TD),
        .SPACE_TIMEOUT (ST)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .nec   (nec)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int v_cnt = 0, r_cnt = 0, e_cnt = 0, overlap = 0;
    int v_cyc = -1, r_cyc = -1, e_cyc = -1;
    always @(negedge Clk) begin
        if (nec.Valid)  begin v_cnt++; v_cyc = cyc; end
        if (nec.Repeat) begin r_cnt++; r_cyc = cyc; end
        if (nec.Error)  begin e_cnt++; e_cyc = cyc; end
        if (int'(nec.Valid) + int'(nec.Repeat) + int'(nec.Error) > 1) overlap++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive level for n clocks; changes land just after a rising edge.
    task automatic seg(input logic lvl, input int n);
        nec.Input = lvl;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            seg(1'b0, 64);
            seg(1'b1, d[i] ? 192 : 64);
        end
    endtask

    task automatic send_frame(input logic [31:0] d, output int c_stop);
        seg(1'b0, 1024);
        seg(1'b1, 512);
        send_bits(d, 32);
        seg(1'b0, 64);
        c_stop = cyc;
        seg(1'b1, 40);
    endtask

    task automatic send_repeat(output int c_end);
        seg(1'b0, 1024);
        seg(1'b1, 256);
        seg(1'b0, 64);
        c_end = cyc;
        seg(1'b1, 40);
    endtask

    int c0;
    int ev, er, ee;

    initial begin
        nec.Input = 1'b1;
        Reset     = 1'b0;
        seg(1'b1, 3);
        check("rst_addr",   32'(nec.Address), 32'h0);
        check("rst_cmd",    32'(nec.Command), 32'h0);
        check("rst_valid",  32'(nec.Valid),   32'h0);
        check("rst_repeat", 32'(nec.Repeat),  32'h0);
        check("rst_error",  32'(nec.Error),   32'h0);
        Reset = 1'b1;
        seg(1'b1, 20);

        // Nominal frame: addr 04/FB, cmd 08/F7
        send_frame(32'hF708FB04, c0);
        check("t1_vcnt",  32'(v_cnt), 32'd1);
        check("t1_vcyc",  32'(v_cyc), 32'(c0 + 2));
        check("t1_addr",  32'(nec.Address), 32'h0004);
        check("t1_cmd",   32'(nec.Command), 32'h08);
        check("t1_rcnt",  32'(r_cnt), 32'd0);
        check("t1_ecnt",  32'(e_cnt), 32'd0);

        send_repeat(c0);
        check("t2_rcnt",  32'(r_cnt), 32'd1);
        check("t2_rcyc",  32'(r_cyc), 32'(c0 + 2));
        check("t2_addr",  32'(nec.Address), 32'h0004);
        check("t2_cmd",   32'(nec.Command), 32'h08);
        check("t2_vcnt",  32'(v_cnt), 32'd1);

        // Command inverse broken: Error, Held cleared, repeat ignored
        send_frame(32'hF608FB04, c0);
        check("t3_ecnt",  32'(e_cnt), 32'd1);
        check("t3_ecyc",  32'(e_cyc), 32'(c0 + 2));
        check("t3_vcnt",  32'(v_cnt), 32'd1);
        send_repeat(c0);
        check("t3_rcnt",  32'(r_cnt), 32'd1);
        check("t3_ecnt2", 32'(e_cnt), 32'd1);

        // Truncated after 12 bits: space timeout fires TD*ST+3 clocks after the last mark ends
        seg(1'b0, 1024);
        seg(1'b1, 512);
        send_bits(32'hF708FB04, 11);
        seg(1'b0, 64);
        c0 = cyc;
        seg(1'b1, TD * ST + 40);
        check("t4_ecnt",  32'(e_cnt), 32'd2);
        check("t4_ecyc",  32'(e_cyc), 32'(c0 + TD * ST + 3));
        check("t4_vcnt",  32'(v_cnt), 32'd1);
        send_frame(32'hEF10FB04, c0);
        check("t4_vcnt2", 32'(v_cnt), 32'd2);
        check("t4_cmd",   32'(nec.Command), 32'h10);

        // Reset pulse in the middle of bit 20's mark
        seg(1'b0, 1024);
        seg(1'b1, 512);
        send_bits(32'hF708FB04, 20);
        seg(1'b0, 30);
        Reset = 1'b0;
        seg(1'b0, 1);
        Reset = 1'b1;
        check("t5_addr0", 32'(nec.Address), 32'h0);
        check("t5_cmd0",  32'(nec.Command), 32'h0);
        seg(1'b0, 33);
        send_bits(32'h00007BC4, 11);
        seg(1'b0, 64);
        seg(1'b1, 40);
        check("t5_vcnt",  32'(v_cnt), 32'd2);
        check("t5_ecnt",  32'(e_cnt), 32'd2);
        check("t5_rcnt",  32'(r_cnt), 32'd1);
        send_frame(32'hF708FB04, c0);
        check("t5_vcnt2", 32'(v_cnt), 32'd3);
        check("t5_addr",  32'(nec.Address), 32'h0004);
        check("t5_cmd",   32'(nec.Command), 32'h08);

        // Address byte1 not the inverse of byte0
        send_frame(32'hF7081204, c0);
`ifdef NEC_EXT_ADDR_EN
        ev = 4; ee = 2;
        check("t6_addr",  32'(nec.Address), 32'h1204);
`else
        ev = 3; ee = 3;
        check("t6_addr",  32'(nec.Address), 32'h0004);
`endif
        er = 1;
        check("t6_vcnt",  32'(v_cnt), 32'(ev));
        check("t6_ecnt",  32'(e_cnt), 32'(ee));
        check("t6_rcnt",  32'(r_cnt), 32'(er));
        check("overlap",  32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
